// File: rtl/operand_fetch_stage.sv
// ID-stage operand collector: decodes rs/rt/imm/dest, captures register_file data into an ID/EX register.
// Optional macro OPFETCH_BYPASS_EN adds same-cycle writeback bypass and refresh of stalled operands.
module operand_fetch_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [DATA_W-1:0] in_pc,
   output logic [ADDR_W-1:0] RX,
   output logic [ADDR_W-1:0] RY,
   input  logic [DATA_W-1:0] busX,
   input  logic [DATA_W-1:0] busY,
   input  logic              wb_wen,
   input  logic [ADDR_W-1:0] wb_rw,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_instr,
   output logic [DATA_W-1:0] out_rs_val,
   output logic [DATA_W-1:0] out_rt_val,
   output logic [DATA_W-1:0] out_imm,
   output logic [ADDR_W-1:0] out_dest
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] pc_q, pc_d, instr_q, instr_d;
   logic [DATA_W-1:0] rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
   logic [ADDR_W-1:0] dest_q, dest_d;

   logic              load;
   logic [5:0]        opcode;
   logic [DATA_W-1:0] imm_ext, rs_sel, rt_sel, wb_val;
   logic [ADDR_W-1:0] dest_dec;
   logic              refresh_rs, refresh_rt;

   assign opcode   = in_instr[31:26];
   assign RX       = in_instr[21 +: ADDR_W];
   assign RY       = in_instr[16 +: ADDR_W];
   assign in_ready = ~valid_q | out_ready;
   assign load     = in_valid & in_ready & ~flush;

   always_comb begin
      imm_ext = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
      if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
         imm_ext = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
   end

   always_comb begin
      dest_d_dec : begin
         case (opcode)
            6'h00:                      dest_dec = in_instr[11 +: ADDR_W];
            6'h03:                      dest_dec = ADDR_W'(31);
            6'h02, 6'h04, 6'h05, 6'h2B: dest_dec = '0;
            default:                    dest_dec = in_instr[16 +: ADDR_W];
         endcase
      end
   end

`ifdef OPFETCH_BYPASS_EN
   logic wb_hit;
   assign wb_hit     = wb_wen & (wb_rw != '0);
   assign wb_val     = wb_data;
   assign rs_sel     = (wb_hit && wb_rw == RX) ? wb_data : busX;
   assign rt_sel     = (wb_hit && wb_rw == RY) ? wb_data : busY;
   // Held operands track writebacks so a stalled entry never issues stale values.
   assign refresh_rs = valid_q & wb_hit & (wb_rw == instr_q[21 +: ADDR_W]);
   assign refresh_rt = valid_q & wb_hit & (wb_rw == instr_q[16 +: ADDR_W]);
`else
   logic unused_wb;
   assign unused_wb  = ^{wb_wen, wb_rw, wb_data};
   assign wb_val     = '0;
   assign rs_sel     = busX;
   assign rt_sel     = busY;
   assign refresh_rs = 1'b0;
   assign refresh_rt = 1'b0;
`endif

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      imm_d   = imm_q;
      dest_d  = dest_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = in_pc;
         instr_d = in_instr;
         rs_d    = rs_sel;
         rt_d    = rt_sel;
         imm_d   = imm_ext;
         dest_d  = dest_dec;
      end else begin
         if (valid_q && out_ready) valid_d = 1'b0;
         if (refresh_rs) rs_d = wb_val;
         if (refresh_rt) rt_d = wb_val;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         imm_q   <= '0;
         dest_q  <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         imm_q   <= imm_d;
         dest_q  <= dest_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_pc     = pc_q;
   assign out_instr  = instr_q;
   assign out_rs_val = rs_q;
   assign out_rt_val = rt_q;
   assign out_imm    = imm_q;
   assign out_dest   = dest_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: vector table, directed stall/flush/reset sequences, randomized model check.
module tb_operand_fetch_stage;

`ifdef OPFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset;
   logic        in_valid, in_ready, wb_wen, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, busX, busY, wb_data;
   logic [31:0] out_pc, out_instr, out_rs_val, out_rt_val, out_imm;
   logic [4:0]  RX, RY, wb_rw, out_dest;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   operand_fetch_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .RX(RX), .RY(RY), .busX(busX), .busY(busY),
      .wb_wen(wb_wen), .wb_rw(wb_rw), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm), .out_dest(out_dest)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Reference rules written directly from the ISA decode description.
   function automatic logic [31:0] m_imm(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      if (op == 12 || op == 13 || op == 14) return {16'h0000, ins[15:0]};
      return {{16{ins[15]}}, ins[15:0]};
   endfunction

   function automatic logic [4:0] m_dest(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      if (op == 0) return ins[15:11];
      if (op == 3) return 5'd31;
      if (op == 2 || op == 4 || op == 5 || op == 43) return 5'd0;
      return ins[20:16];
   endfunction

   function automatic bit m_hit(input logic wen, input logic [4:0] rw, input logic [4:0] r);
      return BYP && wen && rw != 5'd0 && rw == r;
   endfunction

   typedef struct {
      logic [31:0] instr, bx, by;
      logic        wen;
      logic [4:0]  rw;
      logic [31:0] wd, rs, rt, imm;
      logic [4:0]  dest;
   } vec_t;

   typedef struct {
      bit          valid;
      logic [31:0] pc, instr, rs, rt, imm;
      logic [4:0]  dest;
   } ent_t;

   vec_t tbl[14];
   ent_t m;

   task automatic idle();
      in_valid = 0; flush = 0; wb_wen = 0; wb_rw = 0; wb_data = 0; out_ready = 1;
   endtask

   initial begin
      Reset = 1; idle(); in_instr = 0; in_pc = 0; busX = 0; busY = 0;
      #3;
      chk("reset_valid", {31'b0, out_valid}, 0);
      chk("reset_rs", out_rs_val, 0);
      chk("reset_dest", {27'b0, out_dest}, 0);
      step();
      Reset = 0;
      #1;
      chk("reset_in_ready", {31'b0, in_ready}, 1);

      tbl[0]  = '{32'h00221820, 5, 7, 0, 0, 0, 5, 7, 32'h00001820, 3};
      tbl[1]  = '{32'h00221820, 5, 7, 1, 1, 32'hAA, BYP ? 32'hAA : 32'd5, 7, 32'h00001820, 3};
      tbl[2]  = '{32'h00221820, 5, 7, 1, 0, 32'hAA, 5, 7, 32'h00001820, 3};
      tbl[3]  = '{32'h34048001, 0, 9, 1, 0, 32'hBB, 0, 9, 32'h00008001, 4};
      tbl[4]  = '{32'h20048001, 0, 9, 1, 4, 32'hCC, 0, BYP ? 32'hCC : 32'd9, 32'hFFFF8001, 4};
      tbl[5]  = '{32'h0C000010, 1, 2, 0, 0, 0, 1, 2, 32'h00000010, 31};
      tbl[6]  = '{32'h08000010, 1, 2, 0, 0, 0, 1, 2, 32'h00000010, 0};
      tbl[7]  = '{32'hAC410004, 3, 4, 1, 1, 32'h77, 3, BYP ? 32'h77 : 32'd4, 32'h00000004, 0};
      tbl[8]  = '{32'h10220003, 6, 8, 0, 0, 0, 6, 8, 32'h00000003, 0};
      tbl[9]  = '{32'h14220003, 6, 8, 0, 0, 0, 6, 8, 32'h00000003, 0};
      tbl[10] = '{32'h3822FFFF, 6, 8, 0, 0, 0, 6, 8, 32'h0000FFFF, 2};
      tbl[11] = '{32'h3022FFFF, 6, 8, 0, 0, 0, 6, 8, 32'h0000FFFF, 2};
      tbl[12] = '{32'h8C22FFFC, 6, 8, 0, 0, 0, 6, 8, 32'hFFFFFFFC, 2};
      tbl[13] = '{32'h00A50820, 11, 12, 1, 5, 32'h1234, BYP ? 32'h1234 : 32'd11,
                  BYP ? 32'h1234 : 32'd12, 32'h00000820, 1};

      // Back-to-back loads with out_ready held high.
      for (int i = 0; i < 14; i++) begin
         in_valid = 1; out_ready = 1; in_instr = tbl[i].instr; in_pc = 32'h1000 + 32'(4 * i);
         busX = tbl[i].bx; busY = tbl[i].by;
         wb_wen = tbl[i].wen; wb_rw = tbl[i].rw; wb_data = tbl[i].wd;
         #1;
         chk($sformatf("v%0d_RX", i), {27'b0, RX}, {27'b0, tbl[i].instr[25:21]});
         chk($sformatf("v%0d_RY", i), {27'b0, RY}, {27'b0, tbl[i].instr[20:16]});
         step();
         chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 1);
         chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
         chk($sformatf("v%0d_instr", i), out_instr, tbl[i].instr);
         chk($sformatf("v%0d_rs", i), out_rs_val, tbl[i].rs);
         chk($sformatf("v%0d_rt", i), out_rt_val, tbl[i].rt);
         chk($sformatf("v%0d_imm", i), out_imm, tbl[i].imm);
         chk($sformatf("v%0d_dest", i), {27'b0, out_dest}, {27'b0, tbl[i].dest});
      end
      idle();
      step();
      chk("drain_valid", {31'b0, out_valid}, 0);
      chk("drain_hold_instr", out_instr, 32'h00A50820);

      // Stall with writeback refresh, then drain + load on the same edge.
      in_valid = 1; out_ready = 0; in_instr = 32'h00221820; in_pc = 32'h400; busX = 5; busY = 7;
      step();
      chk("stall_load_valid", {31'b0, out_valid}, 1);
      in_instr = 32'h34048001; busX = 32'hDEAD; busY = 32'hBEEF;
      wb_wen = 1; wb_rw = 2; wb_data = 32'h55;
      #1;
      chk("stall_in_ready", {31'b0, in_ready}, 0);
      step();
      chk("stall_rt_refresh", out_rt_val, BYP ? 32'h55 : 32'd7);
      chk("stall_rs_kept", out_rs_val, 5);
      chk("stall_instr_held", out_instr, 32'h00221820);
      wb_rw = 1; wb_data = 32'h66;
      step();
      chk("stall_rs_refresh", out_rs_val, BYP ? 32'h66 : 32'd5);
      chk("stall_valid", {31'b0, out_valid}, 1);
      wb_wen = 0; out_ready = 1; busX = 0; busY = 32'h11; in_pc = 32'h404;
      #1;
      chk("release_in_ready", {31'b0, in_ready}, 1);
      step();
      chk("b2b_valid", {31'b0, out_valid}, 1);
      chk("b2b_instr", out_instr, 32'h34048001);
      chk("b2b_rt", out_rt_val, 32'h11);
      chk("b2b_imm", out_imm, 32'h00008001);

      // Flush beats a pending load and a held entry.
      in_valid = 1; out_ready = 0; flush = 1; in_instr = 32'h08000010; in_pc = 32'h999;
      step();
      chk("flush_valid", {31'b0, out_valid}, 0);
      chk("flush_instr_hold", out_instr, 32'h34048001);
      chk("flush_pc_hold", out_pc, 32'h404);
      flush = 0; in_instr = 32'h0C000010; in_pc = 32'h408; out_ready = 1;
      step();
      chk("jal_valid", {31'b0, out_valid}, 1);
      chk("jal_dest", {27'b0, out_dest}, 31);
      in_valid = 0; in_instr = 32'h03E20000;
      #1;
      chk("idle_RX", {27'b0, RX}, 31);
      chk("idle_RY", {27'b0, RY}, 2);

      // Asynchronous reset while an entry is held.
      in_valid = 1; out_ready = 0; in_instr = 32'h00221820; busX = 5; busY = 7;
      step();
      step();
      chk("pre_reset_valid", {31'b0, out_valid}, 1);
      #2; Reset = 1;
      #1;
      chk("async_reset_valid", {31'b0, out_valid}, 0);
      chk("async_reset_rs", out_rs_val, 0);
      chk("async_reset_instr", out_instr, 0);
      #1; Reset = 0; idle();
      step();
      chk("post_reset_in_ready", {31'b0, in_ready}, 1);
      chk("post_reset_valid", {31'b0, out_valid}, 0);

      // Randomized run against the transaction model.
      m = '{valid: 0, pc: 0, instr: 0, rs: 0, rt: 0, imm: 0, dest: 0};
      for (int c = 0; c < 2000; c++) begin
         bit rdy;
         logic [5:0] ops [11] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43};
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         flush     = $urandom_range(0, 15) == 0;
         wb_wen    = flush ? 1'b0 : 1'($urandom_range(0, 1));
         wb_rw     = 5'($urandom_range(0, 3));
         wb_data   = $urandom;
         busX = $urandom; busY = $urandom; in_pc = $urandom;
         in_instr = {ops[$urandom_range(0, 10)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 11'($urandom)};
         #1;
         rdy = !m.valid || out_ready;
         chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, rdy});
         chk("rnd_RX", {27'b0, RX}, {27'b0, in_instr[25:21]});
         chk("rnd_RY", {27'b0, RY}, {27'b0, in_instr[20:16]});
         if (flush) begin
            m.valid = 0;
         end else if (in_valid && rdy) begin
            m.valid = 1; m.pc = in_pc; m.instr = in_instr;
            m.rs = m_hit(wb_wen, wb_rw, in_instr[25:21]) ? wb_data : busX;
            m.rt = m_hit(wb_wen, wb_rw, in_instr[20:16]) ? wb_data : busY;
            m.imm = m_imm(in_instr); m.dest = m_dest(in_instr);
         end else if (m.valid) begin
            if (m_hit(wb_wen, wb_rw, m.instr[25:21])) m.rs = wb_data;
            if (m_hit(wb_wen, wb_rw, m.instr[20:16])) m.rt = wb_data;
            if (out_ready) m.valid = 0;
         end
         step();
         chk("rnd_valid", {31'b0, out_valid}, {31'b0, m.valid});
         chk("rnd_pc", out_pc, m.pc);
         chk("rnd_instr", out_instr, m.instr);
         chk("rnd_rs", out_rs_val, m.rs);
         chk("rnd_rt", out_rt_val, m.rt);
         chk("rnd_imm", out_imm, m.imm);
         chk("rnd_dest", {27'b0, out_dest}, {27'b0, m.dest});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- ID-stage operand collector sitting directly in front of register_file in the pipelined MIPS core.
- Decodes register specifiers from the incoming instruction, drives RX/RY, captures busX/busY into an ID/EX output register, and bypasses same-cycle writeback data.
- register_file has no internal write-through, so this bypass is required.
- Valid/ready handshake on both sides; flush input from branch/hazard control.

Parameters:
DATA_W, 32, data/instruction/PC width
ADDR_W, 5, register specifier width

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream (IF/ID) entry valid
in_ready  output  1  stage can accept an entry this cycle
in_instr  input  DATA_W  instruction word
in_pc  input  DATA_W  PC+4 of instruction
RX  output  ADDR_W  to register_file read port X = in_instr[25:21]
RY  output  ADDR_W  to register_file read port Y = in_instr[20:16]
busX  input  DATA_W  register_file read data X
busY  input  DATA_W  register_file read data Y
wb_wen  input  1  writeback enable (same signal driving register_file WEN)
wb_rw  input  ADDR_W  writeback address (register_file RW)
wb_data  input  DATA_W  writeback data (register_file busW)
flush  input  1  kill the held entry and the entry being accepted
out_valid  output  1  ID/EX entry valid
out_ready  input  1  downstream accepts entry
out_pc  output  DATA_W  latched in_pc
out_instr  output  DATA_W  latched instruction
out_rs_val  output  DATA_W  rs operand
out_rt_val  output  DATA_W  rt operand
out_imm  output  DATA_W  extended immediate
out_dest  output  ADDR_W  destination register

Behaviour:
- Reset (async, Reset=1): out_valid=0; all out_* data registers=0. in_ready=1 once Reset deasserts.
- RX/RY: purely combinational from in_instr, driven even when in_valid=0.
- in_ready = ~out_valid | out_ready (combinational; no skid buffer).
- Load on a rising edge when in_valid & in_ready & ~flush. All out_* update; out_valid<=1. Latency: 1 cycle.
- No load but out_valid & out_ready: out_valid<=0, data regs hold.
- Load and drain in the same cycle: back-to-back, out_valid stays 1.
- flush=1 has highest priority: out_valid<=0 next edge regardless of in_valid/out_ready; no load occurs.
- Operand select at load:
  - rs value = wb_data if wb_wen & wb_rw!=0 & wb_rw==RX, else busX.
  - rt value analogous with RY/busY.
  - Register 0 never bypassed, so it is always 0 via register_file.
- Held-entry refresh: while out_valid=1 and no load occurs, a wb write (wb_wen, wb_rw!=0) matching out_instr[25:21] / [20:16] overwrites out_rs_val / out_rt_val with wb_data. This keeps stalled operands from going stale.
- Immediate: opcode in_instr[31:26] in {0x0C andi, 0x0D ori, 0x0E xori} zero-extends in_instr[15:0]; all other opcodes sign-extend.
- Destination:
  - opcode 0x00 (R-type) -> in_instr[15:11]
  - opcode 0x03 (jal) -> 31
  - 0x02 j, 0x04 beq, 0x05 bne, 0x2B sw -> 0
  - otherwise in_instr[20:16]
- Reset mid-operation: the held entry is discarded immediately; out_valid drops asynchronously.

Optional Feature:
- Macro OPFETCH_BYPASS_EN.
- Defined: wb bypass at load and held-entry refresh as specified above.
- Undefined: rs/rt values are busX/busY unmodified, and held entries are never refreshed. Hazard control must insert a bubble for a same-cycle writeback read. No wb_* port is removed; the wb_* inputs are ignored.

Test Plan:
- Reset=1 mid-stream with out_valid=1 -> out_valid=0 and out_rs_val=0 immediately; after release, in_ready=1.
- Load add $3,$1,$2 (0x00221820) with busX=5, busY=7, no wb -> next cycle out_valid=1, out_rs_val=5, out_rt_val=7, out_dest=3.
- Same instr with wb_wen=1, wb_rw=1, wb_data=0xAA (bypass enabled) -> out_rs_val=0xAA, out_rt_val=7. Repeat with wb_rw=0 -> out_rs_val=busX.
- out_ready=0 holding entry (rt=$2); wb_wen=1, wb_rw=2, wb_data=0x55 -> out_rt_val=0x55, in_ready=0. Then out_ready=1 -> entry drains and a new entry loads the same edge.
- ori $4,$0,0x8001 (0x34048001) -> out_imm=0x00008001, out_dest=4; addi $4,$0,0x8001 (0x20048001) -> out_imm=0xFFFF8001.
- flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and data regs unchanged; jal (0x0C000010) loaded next -> out_dest=31.
